multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle MIPS core: sequences fetch/decode/execute/mem/writeback over the shared ALU, register file and unified memory.
//  Drives all datapath selects and enables; ALU function comes from the existing alu_decoder (aluop + funct).
//  Stalls on a ready-based memory handshake.
// PARAMETERS
//  MEM_TO_CYCLES  255  max cycles waiting for mem_ready before abort; 0 = no timeout
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  opcode      in   6  instr[31:26] from instruction register
//  funct       in   6  instr[5:0]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes current access this cycle
//  pcen        out  1  PC write enable = pcwrite | (branch & zero)
//  iord        out  1  mem address: 0=PC, 1=ALUOut
//  memread     out  1  memory read request, held until mem_ready
//  memwrite    out  1  memory write request, held until mem_ready
//  irwrite     out  1  load instruction register
//  regdst      out  1  rf write addr: 0=rt, 1=rd
//  memtoreg    out  1  rf write data: 0=ALUOut, 1=MDR
//  regwrite    out  1  register file write enable
//  alusrca     out  1  ALU A: 0=PC, 1=rs reg
//  alusrcb     out  2  ALU B: 00=rt reg, 01=4, 10=signimm, 11=signimm<<2
//  pcsrc       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alucontrol  out  4  from alu_decoder
//  state       out  4  current state code (debug)
//  illegal     out  1  1-cycle pulse: unknown opcode in DECODE
//  mem_err     out  1  1-cycle pulse: memory timeout abort
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, timeout counter=0, illegal=mem_err=0; outputs = FETCH-state decode with mem_ready=0.
//  All outputs combinational from state (+mem_ready, zero, funct); state/counter registered.
//  States and outputs (unlisted outputs 0; aluop: 00 add, 01 sub, 10 funct):
//   FETCH: memread, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite & pcwrite only when mem_ready -> DECODE, else stay.
//   DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target). lw/sw->MEMADR, R(000000)->EXEC, beq(000100)->BRANCH,
//     addi(001000)->ADDIEX, j(000010)->JUMP, other -> FETCH with illegal pulse.
//   MEMADR: alusrca=1, alusrcb=10, aluop=00; lw->MEMRD, sw->MEMWR.
//   MEMRD: memread, iord=1; mem_ready -> MEMWB. MEMWB: regwrite, regdst=0, memtoreg=1 -> FETCH.
//   MEMWR: memwrite, iord=1; mem_ready -> FETCH.
//   EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB. ALUWB: regwrite, regdst=1, memtoreg=0 -> FETCH.
//   BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch -> FETCH.
//   ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB. ADDIWB: regwrite, regdst=0 -> FETCH.
//   JUMP: pcwrite, pcsrc=10 -> FETCH.
//  Timeout: counter clears on entry to FETCH/MEMRD/MEMWR, increments each waiting cycle; when it reaches MEM_TO_CYCLES
//   with mem_ready=0 -> mem_err pulse, go FETCH, no irwrite/pcwrite/regwrite; FETCH timeout re-enters FETCH (refetch).
//   mem_ready on the timeout cycle wins (normal completion). Counter saturates, 8-bit min width.
//  mem_ready outside FETCH/MEMRD/MEMWR ignored. Reset mid-access drops memread/memwrite immediately.
//  Unused state codes -> FETCH.
// CONFIGURATION
//  MC_CTRL_BNE_EN defined: opcode 000101 (bne) decodes -> BNE state, same as BRANCH but pcen = pcwrite | (branch & ~zero).
//  Undefined: 000101 is illegal (pulse, back to FETCH); BNE state code unused.
// STRUCTURE
//  Shared header mips_defs.vh: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J),
//   4-bit state codes (S_FETCH=0 .. S_BNE), aluop codes, alusrcb/pcsrc encodings.
//  One sub-module: alu_decoder (existing) instantiated for alucontrol; FSM, output decode and timeout counter inline.
// TESTING
//  lw, mem_ready=1 always -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1,memtoreg=1 in MEMWB only.
//  R-type add (funct 100000) -> EXEC alucontrol=0010, ALUWB regdst=1 regwrite=1; 4 cycles total.
//  beq zero=1 -> pcen=1,pcsrc=01 in BRANCH; zero=0 -> pcen=0; opcode 000101 illegal pulse unless MC_CTRL_BNE_EN.
//  FETCH with mem_ready low 3 cycles -> memread held, irwrite=pcen=0 until 4th cycle, then DECODE.
//  MEM_TO_CYCLES=4, sw, mem_ready never -> mem_err pulse after 4 wait cycles, no memwrite after, state FETCH.
//  rst_n low mid-MEMWR -> state=0, memwrite=0 same cycle (async); release -> FETCH memread=1.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, state codes,
// ALU-op codes and datapath select encodings.
package multicycle_controller_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes understood by the ALU decoder
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Controller state codes (visible on the debug state port)
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11,
        StBne    = 4'd12
    } state_e;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Timeout counter width: wide enough for the limit, never narrower than 8 bits
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the controller's ALU-op class plus the R-type funct field
// onto the 4-bit ALU control code.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alucontrol
);

    // Fixed add/sub for address and branch math, funct-driven for R-type
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over the shared datapath and stalls on a ready-based memory handshake with an
// optional abort timeout (MEM_TO_CYCLES, 0 disables it).
// Build option: define MC_CTRL_BNE_EN to decode bne (opcode 000101) into the BNE
// state; otherwise that opcode is reported as illegal.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TO_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic [3:0] state,
    output logic       illegal,
    output logic       mem_err
);

    localparam int unsigned CntW = cnt_width(MEM_TO_CYCLES);
    localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TO_CYCLES);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wait_st;
    logic            timeout;
    logic            pcwrite;
    logic            branch;
    logic            branch_ne;
    logic [1:0]      aluop;

    assign state   = state_q;
    assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // A completing access on the limit cycle wins over the abort
    assign timeout = (MEM_TO_CYCLES != 0) && wait_st && !mem_ready && (cnt_q == CntLimit);
    assign mem_err = timeout;
    assign pcen    = pcwrite | (branch & zero) | (branch_ne & ~zero);

    // Per-state datapath controls and next-state selection
    always_comb begin
        state_d   = StFetch;
        iord      = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = SRCB_REG;
        pcsrc     = PCSRC_ALU;
        aluop     = ALUOP_ADD;
        pcwrite   = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            StFetch: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = StDecode;
                end else begin
                    // Stay put while waiting; a timeout also lands here (refetch)
                    state_d = StFetch;
                end
            end
            StDecode: begin
                // Precompute the branch target while the opcode is decoded
                alusrcb = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = StBne;
`else
                    OP_BNE: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready)    state_d = StMemWb;
                else if (timeout) state_d = StFetch;
                else              state_d = StMemRd;
            end
            StMemWb: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                state_d  = (mem_ready || timeout) ? StFetch : StMemWr;
            end
            StExec: begin
                alusrca = 1'b1;
                alusrcb = SRCB_REG;
                aluop   = ALUOP_FUNCT;
                state_d = StAluWb;
            end
            StAluWb: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                state_d = StFetch;
            end
`ifdef MC_CTRL_BNE_EN
            StBne: begin
                alusrca   = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc     = PCSRC_ALUOUT;
                branch_ne = 1'b1;
                state_d   = StFetch;
            end
`endif
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StJump: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Wait counter: cleared on any state entry (including refetch), saturating
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || timeout) begin
            cnt_d = '0;
        end else if (wait_st && !mem_ready && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    multicycle_controller_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TO_CYCLES=4). Each observation is
// the packed tuple {state, controls, alucontrol, illegal, mem_err}, taken at the
// falling clock edge plus 1.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol, state;
    logic       illegal, mem_err;

    int n_vec = 0;
    int n_err = 0;

    multicycle_controller #(.MEM_TO_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state),
        .illegal    (illegal),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    // {state[4], pcen iord memread memwrite irwrite regdst memtoreg regwrite alusrca
    //  alusrcb[2] pcsrc[2], alucontrol[4], illegal, mem_err}
    logic [22:0] obs;
    assign obs = {state, pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, pcsrc, alucontrol, illegal, mem_err};

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;
    localparam logic [3:0] S_BNE = 4'd12;

    localparam logic [12:0] C_F0  = 13'b0010000000100; // fetch, waiting
    localparam logic [12:0] C_F1  = 13'b1010100000100; // fetch, completing
    localparam logic [12:0] C_DEC = 13'b0000000001100;
    localparam logic [12:0] C_ADR = 13'b0000000011000; // memadr / addiex
    localparam logic [12:0] C_MRD = 13'b0110000000000;
    localparam logic [12:0] C_MWB = 13'b0000001100000;
    localparam logic [12:0] C_MWR = 13'b0101000000000;
    localparam logic [12:0] C_EXE = 13'b0000000010000;
    localparam logic [12:0] C_AWB = 13'b0000010100000;
    localparam logic [12:0] C_BR1 = 13'b1000000010001; // branch taken
    localparam logic [12:0] C_BR0 = 13'b0000000010001; // branch not taken
    localparam logic [12:0] C_AIW = 13'b0000000100000;
    localparam logic [12:0] C_JMP = 13'b1000000000010;

    localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_SLT = 4'b0111;

    task automatic test_reset();
        logic [22:0] exp_v;
        exp_v = {S_FETCH, C_F0, A_ADD, 2'b00};
        #1;
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [22:0] seq [6];
        bit          rdy [6];
        seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                {S_MEMADR, C_ADR, A_ADD, 2'b00}, {S_MEMRD, C_MRD, A_ADD, 2'b00},
                {S_MEMWB, C_MWB, A_ADD, 2'b00}, {S_FETCH, C_F0, A_ADD, 2'b00}};
        rdy = '{1, 1, 1, 1, 1, 0};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            mem_ready = rdy[i];
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL lw step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn    [2];
        logic [3:0]  alu_x [2];
        logic [22:0] seq   [5];
        fn    = '{6'b100000, 6'b101010};
        alu_x = '{A_ADD, A_SLT};
        opcode = 6'b000000;
        for (int k = 0; k < 2; k++) begin
            funct = fn[k];
            seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                    {S_EXEC, C_EXE, alu_x[k], 2'b00}, {S_ALUWB, C_AWB, A_ADD, 2'b00},
                    {S_FETCH, C_F0, A_ADD, 2'b00}};
            for (int i = 0; i < 5; i++) begin
                if (i != 0) @(negedge clk);
                mem_ready = (i != 4);
                #1;
                n_vec++;
                if (obs !== seq[i]) begin
                    n_err++;
                    $display("FAIL rtype%0d step %0d: got %h want %h", k, i, obs, seq[i]);
                end
            end
        end
    endtask

    task automatic test_beq();
        logic [12:0] br_x [2];
        logic [22:0] seq  [4];
        br_x = '{C_BR1, C_BR0};
        opcode = 6'b000100;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                    {S_BRANCH, br_x[k], A_SUB, 2'b00}, {S_FETCH, C_F0, A_ADD, 2'b00}};
            for (int i = 0; i < 4; i++) begin
                if (i != 0) @(negedge clk);
                mem_ready = (i != 3);
                #1;
                n_vec++;
                if (obs !== seq[i]) begin
                    n_err++;
                    $display("FAIL beq zero=%0d step %0d: got %h want %h", zero, i, obs, seq[i]);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_addi_jump();
        logic [22:0] seq [5];
        opcode = 6'b001000;
        seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                {S_ADDIEX, C_ADR, A_ADD, 2'b00}, {S_ADDIWB, C_AIW, A_ADD, 2'b00},
                {S_FETCH, C_F0, A_ADD, 2'b00}};
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            mem_ready = (i != 4);
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL addi step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
        opcode = 6'b000010;
        seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                {S_JUMP, C_JMP, A_ADD, 2'b00}, {S_FETCH, C_F0, A_ADD, 2'b00}, 23'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i != 3);
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL jump step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [22:0] seq [4];
        int          n;
        // Unknown opcode: illegal pulse in DECODE, then straight back to FETCH
        opcode = 6'b111111;
        seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b10},
                {S_FETCH, C_F0, A_ADD, 2'b00}, 23'd0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = (i != 2);
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL illegal step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
        opcode = 6'b000101;
        zero   = 1'b0;
`ifdef MC_CTRL_BNE_EN
        seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                {S_BNE, C_BR1, A_SUB, 2'b00}, {S_FETCH, C_F0, A_ADD, 2'b00}};
        n = 4;
`else
        seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b10},
                {S_FETCH, C_F0, A_ADD, 2'b00}, 23'd0};
        n = 3;
`endif
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = (i != n - 1);
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL bne step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
    endtask

    task automatic test_fetch_stall();
        logic [22:0] seq [7];
        bit          rdy [7];
        opcode = 6'b000010;
        seq = '{{S_FETCH, C_F0, A_ADD, 2'b00}, {S_FETCH, C_F0, A_ADD, 2'b00},
                {S_FETCH, C_F0, A_ADD, 2'b00}, {S_FETCH, C_F1, A_ADD, 2'b00},
                {S_DECODE, C_DEC, A_ADD, 2'b00}, {S_JUMP, C_JMP, A_ADD, 2'b00},
                {S_FETCH, C_F0, A_ADD, 2'b00}};
        rdy = '{0, 0, 0, 1, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mem_ready = rdy[i];
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL fetch_stall step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
    endtask

    task automatic test_fetch_timeout();
        logic [22:0] exp_v;
        // Counter is 0 on the first cycle of this FETCH; abort on the 5th waiting cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            exp_v = {S_FETCH, C_F0, A_ADD, 1'b0, (i == 4)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL fetch_timeout step %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_sw();
        logic [22:0] seq [10];
        bit          rdy [10];
        opcode = 6'b101011;
        // Normal store, then a store whose memory never answers
        seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                {S_MEMADR, C_ADR, A_ADD, 2'b00}, {S_MEMWR, C_MWR, A_ADD, 2'b00},
                {S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                {S_MEMADR, C_ADR, A_ADD, 2'b00}, {S_MEMWR, C_MWR, A_ADD, 2'b00},
                {S_MEMWR, C_MWR, A_ADD, 2'b00}, {S_MEMWR, C_MWR, A_ADD, 2'b00}};
        rdy = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = rdy[i];
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL sw step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
        seq[0] = {S_MEMWR, C_MWR, A_ADD, 2'b00};
        seq[1] = {S_MEMWR, C_MWR, A_ADD, 2'b01};
        seq[2] = {S_FETCH, C_F0, A_ADD, 2'b00};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL sw_timeout step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [22:0] seq [6];
        opcode = 6'b101011;
        seq = '{{S_FETCH, C_F1, A_ADD, 2'b00}, {S_DECODE, C_DEC, A_ADD, 2'b00},
                {S_MEMADR, C_ADR, A_ADD, 2'b00}, {S_MEMWR, C_MWR, A_ADD, 2'b00},
                {S_FETCH, C_F0, A_ADD, 2'b00}, {S_FETCH, C_F0, A_ADD, 2'b00}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i < 3);
            #1;
            n_vec++;
            if (obs !== seq[i]) begin
                n_err++;
                $display("FAIL async_reset step %0d: got %h want %h", i, obs, seq[i]);
            end
        end
        // Assert reset between clock edges: must take effect immediately
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== seq[4]) begin
            n_err++;
            $display("FAIL async_reset in-reset: got %h want %h", obs, seq[4]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (obs !== seq[5]) begin
            n_err++;
            $display("FAIL async_reset released: got %h want %h", obs, seq[5]);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_addi_jump();
        test_illegal();
        test_fetch_stall();
        test_fetch_timeout();
        test_sw();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

endmodule
